// File: rtl/rc5_decipher_pkg.sv
// Shared constants and state encoding for the RC5-32/12 decryption core.
// Word width, round count and the S-table size all derive from here.
package rc5_decipher_pkg;

  localparam int W         = 32;
  localparam int R         = 12;
  localparam int S_SIZE    = 2 * R + 2;
  localparam int R_BIT     = $clog2(S_SIZE);
  localparam int ROT_VALUE = $clog2(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } rc5_state_e;

endpackage

// File: rtl/rc5_decipher_if.sv
// Start/data, S-table read port and result signals of the RC5 decryption core.
// Handshake: iStart is honoured only while the core is idle (oBusy=0, oDone=0); oDone pulses one cycle with the result.
interface rc5_decipher_if;
  import rc5_decipher_pkg::*;

  logic          iStart;
  logic [W-1:0]  iA;
  logic [W-1:0]  iB;
  logic [W-1:0]  oS_address;
  logic [W-1:0]  iS_sub_i;
  logic [W-1:0]  oA_plain;
  logic [W-1:0]  oB_plain;
  logic          oBusy;
  logic          oDone;
  rc5_state_e    state_dbg;

  modport slave (
    input  iStart, iA, iB, iS_sub_i,
    output oS_address, oA_plain, oB_plain, oBusy, oDone, state_dbg
  );

  modport master (
    output iStart, iA, iB, iS_sub_i,
    input  oS_address, oA_plain, oB_plain, oBusy, oDone, state_dbg
  );

endinterface

// File: rtl/rc5_decipher_barrel_rotr.sv
// Combinational right rotate built as a log2(W)-stage shifter.
module rc5_decipher_barrel_rotr #(
  parameter int W         = 32,
  parameter int ROT_VALUE = $clog2(W)
) (
  input  logic [W-1:0]         iData,
  input  logic [ROT_VALUE-1:0] iRotate,
  output logic [W-1:0]         oData
);

  logic [W-1:0] stage [0:ROT_VALUE];

  assign stage[0] = iData;

  // Stage s rotates right by 2**s when bit s of the amount is set.
  for (genvar s = 0; s < ROT_VALUE; s++) begin : g_stage
    assign stage[s+1] = iRotate[s] ? {stage[s][(2**s)-1:0], stage[s][W-1:(2**s)]}
                                   : stage[s];
  end

  assign oData = stage[ROT_VALUE];

endmodule

// File: rtl/rc5_decipher.sv
// Iterative RC5 decryption: walks the S table from index 2R+1 down to 0,
// one table word per clock, and presents the plaintext pair with a one-cycle oDone.
module rc5_decipher
  import rc5_decipher_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rc5_decipher_if.slave bus
);

  localparam logic [R_BIT-1:0] K_TOP     = R_BIT'(S_SIZE - 1);
  localparam logic [W-1:0]     ADDR_TOP  = W'(S_SIZE - 1);
  localparam logic [W-1:0]     ADDR_NEXT = W'(S_SIZE - 2);

  rc5_state_e       state_q;
  logic [W-1:0]     ra_q;
  logic [W-1:0]     rb_q;
  logic [R_BIT-1:0] k_q;

  logic [W-1:0]     a_diff;
  logic [W-1:0]     b_diff;
  logic [W-1:0]     a_rot;
  logic [W-1:0]     b_rot;
  logic [R_BIT-1:0] k_dec2;

  assign a_diff = ra_q - bus.iS_sub_i;
  assign b_diff = rb_q - bus.iS_sub_i;
  assign k_dec2 = k_q - R_BIT'(2);

  rc5_decipher_barrel_rotr #(.W(W), .ROT_VALUE(ROT_VALUE)) u_rot_b (
    .iData   (b_diff),
    .iRotate (ra_q[ROT_VALUE-1:0]),
    .oData   (b_rot)
  );

  rc5_decipher_barrel_rotr #(.W(W), .ROT_VALUE(ROT_VALUE)) u_rot_a (
    .iData   (a_diff),
    .iRotate (rb_q[ROT_VALUE-1:0]),
    .oData   (a_rot)
  );

  assign bus.state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ra_q           <= '0;
      rb_q           <= '0;
      k_q            <= '0;
      bus.oS_address <= '0;
      bus.oA_plain   <= '0;
      bus.oB_plain   <= '0;
      bus.oBusy      <= 1'b0;
      bus.oDone      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            ra_q           <= bus.iA;
            rb_q           <= bus.iB;
            k_q            <= K_TOP;
            bus.oS_address <= ADDR_TOP;
            bus.oBusy      <= 1'b1;
            state_q        <= ST_PRIME;
          end
        end

        // First table word is still in flight from the RAM.
        ST_PRIME: begin
          bus.oS_address <= ADDR_NEXT;
          state_q        <= ST_RUN;
        end

        // Address runs two ahead of k: one for the register, one for RAM latency.
        ST_RUN: begin
          if (k_q >= R_BIT'(2)) begin
            bus.oS_address <= {{(W-R_BIT){1'b0}}, k_dec2};
          end
          if (k_q == '0) begin
            ra_q         <= a_diff;
            bus.oA_plain <= a_diff;
            bus.oB_plain <= rb_q;
            bus.oDone    <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            k_q <= k_q - R_BIT'(1);
            if (k_q == R_BIT'(1)) begin
              rb_q <= b_diff;
            end else if (k_q[0]) begin
              rb_q <= b_rot ^ ra_q;
            end else begin
              ra_q <= a_rot ^ rb_q;
            end
          end
        end

        ST_DONE: begin
          bus.oDone <= 1'b0;
          bus.oBusy <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
